// File: rtl/vx_mem_line_sequencer.sv
// Splits one Vortex memory-line request into single-word bus beats and reassembles read lines.
// Optional build macro VX_MEM_SEQ_SKIP_EMPTY_EN: write beats with an all-zero byte enable are skipped.
module vx_mem_line_sequencer #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int LINE_WIDTH      = 512,
    parameter int TAG_WIDTH       = 56,
    parameter int BUS_ADDR_WIDTH  = 32,
    parameter int BUS_DATA_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    input  logic                       mem_req_rw,
    input  logic [LINE_WIDTH/8-1:0]    mem_req_byteen,
    input  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
    input  logic [LINE_WIDTH-1:0]      mem_req_data,
    input  logic [TAG_WIDTH-1:0]       mem_req_tag,
    output logic                       mem_req_ready,
    output logic                       mem_rsp_valid,
    output logic [LINE_WIDTH-1:0]      mem_rsp_data,
    output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
    input  logic                       mem_rsp_ready,
    output logic                       bus_ren,
    output logic                       bus_wen,
    output logic [BUS_ADDR_WIDTH-1:0]  bus_addr,
    output logic [BUS_DATA_WIDTH-1:0]  bus_wdata,
    output logic [BUS_DATA_WIDTH/8-1:0] bus_strobe,
    input  logic [BUS_DATA_WIDTH-1:0]  bus_rdata,
    input  logic                       bus_busy,
    input  logic                       bus_error,
    output logic                       seq_error
);

    localparam int WORDS     = LINE_WIDTH / BUS_DATA_WIDTH;
    localparam int STRB_W    = BUS_DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(WORDS);
    localparam int LINE_OFFS = $clog2(LINE_WIDTH / 8);
    localparam int WORD_SH   = $clog2(BUS_DATA_WIDTH);
    localparam int STRB_SH   = $clog2(STRB_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]                 state;
    logic                       req_rw;
    logic [LINE_WIDTH/8-1:0]    req_byteen;
    logic [LINE_ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0]      req_data;
    logic [TAG_WIDTH-1:0]       req_tag;
    logic [LINE_WIDTH-1:0]      line_buf;
    logic [CNT_W-1:0]           beat_cnt;
    logic                       err_flag;

    logic [CNT_W+WORD_SH-1:0]   word_lsb;
    logic [CNT_W+STRB_SH-1:0]   strb_lsb;
    logic [BUS_ADDR_WIDTH-1:0]  beat_addr;
    logic [STRB_W-1:0]          beat_strobe;
    logic                       last_beat;
    logic                       bus_req;
    logic                       skip_beat;

    assign word_lsb    = {beat_cnt, {WORD_SH{1'b0}}};
    assign strb_lsb    = {beat_cnt, {STRB_SH{1'b0}}};
    assign beat_addr   = BUS_ADDR_WIDTH'({req_addr, {LINE_OFFS{1'b0}}})
                       + BUS_ADDR_WIDTH'({beat_cnt, {STRB_SH{1'b0}}});
    assign beat_strobe = req_rw ? req_byteen[strb_lsb +: STRB_W] : {STRB_W{1'b1}};
    assign last_beat   = (beat_cnt == CNT_W'(WORDS - 1));
    assign bus_req     = bus_ren | bus_wen;

`ifdef VX_MEM_SEQ_SKIP_EMPTY_EN
    assign skip_beat = req_rw && (beat_strobe == '0);
`else
    assign skip_beat = 1'b0;
`endif

    assign mem_req_ready = (state == S_IDLE);
    assign mem_rsp_valid = (state == S_RSP);
    assign mem_rsp_data  = line_buf;
    assign mem_rsp_tag   = req_tag;

    // Requests are registered: a cycle with no request loads the next beat, which guarantees the idle gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            req_rw     <= 1'b0;
            req_byteen <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            req_tag    <= '0;
            line_buf   <= '0;
            beat_cnt   <= '0;
            err_flag   <= 1'b0;
            bus_ren    <= 1'b0;
            bus_wen    <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_strobe <= '0;
            seq_error  <= 1'b0;
        end else begin
            seq_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req_valid) begin
                        req_rw     <= mem_req_rw;
                        req_byteen <= mem_req_byteen;
                        req_addr   <= mem_req_addr;
                        req_data   <= mem_req_data;
                        req_tag    <= mem_req_tag;
                        line_buf   <= '0;
                        beat_cnt   <= '0;
                        err_flag   <= 1'b0;
                        state      <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (!bus_req) begin
                        if (skip_beat) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            if (last_beat) begin
                                state     <= S_IDLE;
                                seq_error <= err_flag;
                            end
                        end else begin
                            bus_addr   <= beat_addr;
                            bus_wdata  <= req_data[word_lsb +: BUS_DATA_WIDTH];
                            bus_strobe <= beat_strobe;
                            bus_ren    <= !req_rw;
                            bus_wen    <= req_rw;
                        end
                    end else if (!bus_busy) begin
                        bus_ren  <= 1'b0;
                        bus_wen  <= 1'b0;
                        err_flag <= err_flag | bus_error;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (!req_rw) begin
                            line_buf[word_lsb +: BUS_DATA_WIDTH] <= bus_rdata;
                        end
                        if (last_beat) begin
                            if (req_rw) begin
                                state     <= S_IDLE;
                                seq_error <= err_flag | bus_error;
                            end else begin
                                state <= S_RSP;
                            end
                        end
                    end
                end
                S_RSP: begin
                    if (mem_rsp_ready) begin
                        state     <= S_IDLE;
                        seq_error <= err_flag;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_mem_line_sequencer.sv
// Self-checking bench for vx_mem_line_sequencer: directed and random line transfers against a beat-list model.
// Honours VX_MEM_SEQ_SKIP_EMPTY_EN to predict skipped write beats.
module tb_vx_mem_line_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [63:0]  mem_req_byteen;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [55:0]  mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [55:0]  mem_rsp_tag;
    logic         mem_rsp_ready;
    logic         bus_ren;
    logic         bus_wen;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_strobe;
    logic [31:0]  bus_rdata;
    logic         bus_busy;
    logic         bus_error;
    logic         seq_error;

    always #5 clk = ~clk;

    vx_mem_line_sequencer dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_error(bus_error),
        .seq_error(seq_error)
    );

    int checks = 0;
    int failures = 0;
    bit skip_en;

    int cfg_busy_beat;
    int cfg_busy_len;
    int cfg_err_beat;
    int cfg_rsp_hold;
    bit cfg_random;
    bit cfg_fixed_rdata;

    int           exp_idx[$];
    logic [511:0] model_line;
    logic         model_err;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge with the sequencer idle
    task automatic run_txn(input logic rw, input logic [25:0] addr, input logic [63:0] be,
                           input logic [511:0] data, input logic [55:0] tag);
        logic [31:0] base;
        logic [31:0] s_addr, s_wdata, rd;
        logic [3:0]  s_strobe, e_strobe;
        logic        err;
        int k, budget, busy_left, ib;
        bit pending, expect_gap, done;

        exp_idx.delete();
        for (int i = 0; i < 16; i++)
            if (!rw || !skip_en || be[4*i +: 4] != 4'h0) exp_idx.push_back(i);
        base = {addr, 6'b0};
        model_line = '0;
        model_err = 1'b0;
        k = 0; budget = 0; busy_left = 0;
        pending = 0; expect_gap = 0; done = 0;
        s_addr = '0; s_wdata = '0; s_strobe = '0;

        check("idle_ready", mem_req_ready, 1'b1);
        mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_byteen = be;
        mem_req_addr = addr; mem_req_data = data; mem_req_tag = tag;
        @(negedge clk);
        mem_req_valid = 1'b0;
        mem_req_data = '0;

        while (!done && budget < 400) begin
            if (rw ? mem_req_ready : mem_rsp_valid) begin
                done = 1;
            end else begin
                check("in_flight_flags", {mem_req_ready, mem_rsp_valid, seq_error}, 3'b000);
                bus_busy = 1'b0;
                bus_error = 1'b0;
                if (expect_gap) begin
                    check("gap_after_beat", {bus_ren, bus_wen}, 2'b00);
                    expect_gap = 0;
                end else if (bus_ren | bus_wen) begin
                    if (pending) begin
                        check("busy_hold_stable", {bus_addr, bus_wdata, bus_strobe},
                              {s_addr, s_wdata, s_strobe});
                    end else if (cfg_random) begin
                        busy_left = $urandom_range(0, 2);
                    end else begin
                        busy_left = (k < exp_idx.size() && exp_idx[k] == cfg_busy_beat) ? cfg_busy_len : 0;
                    end
                    s_addr = bus_addr; s_wdata = bus_wdata; s_strobe = bus_strobe;
                    if (busy_left > 0) begin
                        bus_busy = 1'b1;
                        bus_rdata = $urandom;
                        busy_left--;
                        pending = 1;
                    end else begin
                        if (k < exp_idx.size()) begin
                            ib = exp_idx[k];
                            e_strobe = rw ? be[4*ib +: 4] : 4'hF;
                            check("beat_addr", bus_addr, base + 32'(4 * ib));
                            check("beat_dir", {bus_ren, bus_wen}, {!rw, rw});
                            check("beat_strobe", bus_strobe, e_strobe);
                            if (rw) check("beat_wdata", bus_wdata, data[32*ib +: 32]);
                        end else begin
                            ib = 0;
                            check("beat_overflow", k, exp_idx.size());
                        end
                        rd = cfg_fixed_rdata ? 32'hA000_0000 + 32'(ib) : $urandom;
                        err = cfg_random ? ($urandom_range(0, 5) == 0) : (ib == cfg_err_beat);
                        bus_rdata = rd;
                        bus_error = err;
                        if (!rw) model_line[32*ib +: 32] = rd;
                        model_err = model_err | err;
                        k++;
                        pending = 0;
                        expect_gap = 1;
                    end
                end
                @(negedge clk);
                budget++;
            end
        end
        bus_busy = 1'b0;
        bus_error = 1'b0;
        check("txn_timeout", done, 1'b1);
        check("beat_count", k, exp_idx.size());

        if (!rw) begin
            for (int h = 0; h < cfg_rsp_hold; h++) begin
                check("rsp_hold_valid", {mem_rsp_valid, seq_error}, 2'b10);
                @(negedge clk);
            end
            check("rsp_data", mem_rsp_data, model_line);
            check("rsp_tag", mem_rsp_tag, tag);
            check("rsp_valid", mem_rsp_valid, 1'b1);
            mem_rsp_ready = 1'b1;
            @(negedge clk);
            mem_rsp_ready = 1'b0;
            check("rsp_drop", {mem_rsp_valid, mem_req_ready}, 2'b01);
            check("rd_seq_error", seq_error, model_err);
        end else begin
            check("wr_seq_error", seq_error, model_err);
            check("wr_no_rsp", mem_rsp_valid, 1'b0);
        end
        @(negedge clk);
        check("seq_error_one_cycle", seq_error, 1'b0);
    endtask

    task automatic set_cfg(input int busy_beat, input int busy_len, input int err_beat,
                           input int hold, input bit rnd, input bit fixed);
        cfg_busy_beat = busy_beat; cfg_busy_len = busy_len; cfg_err_beat = err_beat;
        cfg_rsp_hold = hold; cfg_random = rnd; cfg_fixed_rdata = fixed;
    endtask

    initial begin
        logic [511:0] d;
        logic [63:0]  t64, b64;
        int nbeats, budget;

`ifdef VX_MEM_SEQ_SKIP_EMPTY_EN
        skip_en = 1'b1;
`else
        skip_en = 1'b0;
`endif
        reset = 1'b1;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
        mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0;
        mem_rsp_ready = 1'b0; bus_rdata = '0; bus_busy = 1'b0; bus_error = 1'b0;
        set_cfg(-1, 0, -1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_ready_valid", {mem_req_ready, mem_rsp_valid, seq_error}, 3'b100);
        check("rst_bus_req", {bus_ren, bus_wen}, 2'b00);
        check("rst_bus_fields", {bus_addr, bus_wdata, bus_strobe}, '0);
        check("rst_rsp_fields", {mem_rsp_tag, mem_rsp_data}, '0);
        reset = 1'b0;
        @(negedge clk);

        // Directed read with fixed read data and a stalled response
        set_cfg(-1, 0, -1, 3, 0, 1);
        run_txn(1'b0, 26'h0000004, '0, '0, 56'h12_3456_789A_BCDE);

        // Full write with wait states on beat 7
        for (int i = 0; i < 16; i++) d[32*i +: 32] = 32'(i);
        set_cfg(7, 3, -1, 0, 0, 0);
        run_txn(1'b1, 26'h0001234, 64'hFFFF_FFFF_FFFF_FFFF, d, 56'h0);

        // Read with an error on beat 2, random data
        set_cfg(-1, 0, 2, 1, 0, 0);
        run_txn(1'b0, 26'h2AAAAAA, '0, '0, 56'hAB_CDEF_0123_4567);

        // Sparse and empty write enables, top-of-memory read
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        set_cfg(-1, 0, -1, 0, 0, 0);
        run_txn(1'b1, 26'h0000010, 64'h0000_0000_0000_000F, d, 56'h1);
        run_txn(1'b1, 26'h0000020, 64'h0, d, 56'h2);
        set_cfg(-1, 0, 15, 0, 0, 1);
        run_txn(1'b0, 26'h3FFFFFF, '0, '0, 56'h3);

        // Random traffic
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
            t64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            if (n % 3 == 0) b64 = b64 & {$urandom, $urandom} & {$urandom, $urandom};
            set_cfg(-1, 0, -1, $urandom_range(0, 2), 1, 0);
            run_txn(1'($urandom_range(0, 1)), 26'($urandom), b64, d, t64[55:0]);
        end

        // Asynchronous reset in the middle of beat 5 of a read
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h0000100;
        mem_req_tag = 56'h77;
        @(negedge clk);
        mem_req_valid = 1'b0;
        nbeats = 0; budget = 0;
        while (budget < 200 && !((bus_ren | bus_wen) && nbeats == 5)) begin
            if (bus_ren | bus_wen) nbeats++;
            @(negedge clk);
            budget++;
        end
        check("rst_reached_beat5", {nbeats, bus_ren}, {32'd5, 1'b1});
        reset = 1'b1;
        #1;
        check("rst_async_req_drop", {bus_ren, bus_wen}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("post_rst_quiet", {bus_ren, bus_wen, mem_rsp_valid, mem_req_ready, seq_error}, 5'b00010);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_mem_line_sequencer.md
Name: vx_mem_line_sequencer

Overview:
- Sequences one Vortex 512-bit memory-line request into 16 single-word (32-bit) transfers on the generic bus-master request interface that feeds the AHB manager.
- Reads are reassembled into a 512-bit line and returned to Vortex with the original tag. Writes produce no response.
- Sits between the Vortex memory port and the AHB manager inside the Vortex wrapper. It is the only sequencer that drives that manager.

Parameters:
- LINE_ADDR_WIDTH, 26, Vortex line-address width (byte address = {line_addr, 6'b0}).
- LINE_WIDTH, 512, Vortex memory data width.
- TAG_WIDTH, 56, Vortex memory tag width.
- BUS_ADDR_WIDTH, 32, bus byte-address width.
- BUS_DATA_WIDTH, 32, bus word width. WORDS = LINE_WIDTH/BUS_DATA_WIDTH = 16.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- mem_req_valid  in  1  Vortex request valid.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_byteen  in  64  per-byte write enables.
- mem_req_addr  in  LINE_ADDR_WIDTH  line address.
- mem_req_data  in  LINE_WIDTH  write data.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted when valid && ready.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  LINE_WIDTH  assembled read line.
- mem_rsp_tag  out  TAG_WIDTH  tag of completed read.
- mem_rsp_ready  in  1  Vortex accepts response.
- bus_ren  out  1  word read request.
- bus_wen  out  1  word write request.
- bus_addr  out  BUS_ADDR_WIDTH  word byte address.
- bus_wdata  out  BUS_DATA_WIDTH  write word.
- bus_strobe  out  4  write byte enables.
- bus_rdata  in  BUS_DATA_WIDTH  read word.
- bus_busy  in  1  1 = current beat not finished.
- bus_error  in  1  error on the completing beat.
- seq_error  out  1  one-cycle pulse: the transaction that just finished saw any bus_error.

Behaviour:
- Reset values:
  - State is IDLE.
  - mem_req_ready is 1.
  - mem_rsp_valid, bus_ren, bus_wen and seq_error are 0.
  - mem_rsp_data, mem_rsp_tag, bus_addr, bus_wdata and bus_strobe are all zeros.
  - Beat counter and error flag are 0.
- Reset mid-operation: bus_ren/bus_wen drop immediately (async). The in-flight line is discarded and no response is issued.
- States are IDLE, BEAT and RSP.
- IDLE:
  - mem_req_ready = 1.
  - On mem_req_valid, latch rw, byteen, addr, data and tag.
  - Clear the line buffer, beat counter and error flag, then go to BEAT.
- BEAT:
  - mem_req_ready = 0.
  - For beat i (0..15):
    - bus_addr = {addr, 6'b0} + 4*i.
    - bus_wdata = data[32i+:32].
    - bus_strobe = byteen[4i+:4] for writes, 4'hF for reads.
    - bus_ren = !rw and bus_wen = rw.
  - Request signals are held stable while bus_busy = 1.
  - A beat completes in a cycle with a request high and bus_busy = 0. On completion:
    - Reads capture bus_rdata into line[32i+:32].
    - Error flag |= bus_error.
    - i increments.
  - On completion of beat 15:
    - Read: go to RSP.
    - Write: go to IDLE and pulse seq_error if the error flag (including this beat) is set.
  - Requests are deasserted for exactly one cycle between consecutive beats, so there is no back-to-back request without an idle cycle.
- RSP:
  - mem_rsp_valid = 1, with mem_rsp_data = line and mem_rsp_tag = latched tag, held until mem_rsp_ready.
  - On handshake: go to IDLE, pulse seq_error if the error flag is set, and drop mem_rsp_valid next cycle.
- Latency: minimum read is 1 accept + 16 × 2 beat cycles + 1 RSP cycle. The response is not combinationally dependent on mem_req_valid.
- Address arithmetic wraps modulo 2^BUS_ADDR_WIDTH. Beats never cross the 64-byte line because the base is aligned.
- An erroring read word is stored as returned. Errors never abort a sequence.

Optional Feature:
- Macro: VX_MEM_SEQ_SKIP_EMPTY_EN.
- Defined: write beats whose byteen[4i+:4] == 0 are not issued; the counter advances in one cycle with no request. A write with byteen == 0 returns to IDLE after 16 cycles with no bus activity. Reads are unaffected.
- Undefined: all 16 write beats are issued, including those with strobe 4'h0.

Test Plan:
- Reset: assert reset mid-BEAT at beat 5 -> bus_ren/bus_wen 0 in the same cycle; after release mem_req_ready=1, mem_rsp_valid=0 and no further bus requests.
- Read, addr=26'h0000004, bus_busy=0, bus_rdata=0xA000_0000+i:
  - bus_addr steps 0x100..0x13C.
  - mem_rsp_data word i = 0xA000_0000+i, tag echoed.
  - mem_rsp_valid held 3 cycles while mem_rsp_ready=0.
- Write, byteen=64'hFFFF_FFFF_FFFF_FFFF, data word i=i: 16 bus_wen beats with bus_wdata=i, strobe=4'hF; no mem_rsp_valid; mem_req_ready returns to 1.
- Wait states: bus_busy=1 for 3 cycles on beat 7 -> bus_addr/bus_wdata stable throughout; beat 8 starts only after busy drops.
- Error: bus_error=1 on beat 2 of a read -> all 16 beats still issued; seq_error pulses exactly once, on the response handshake.
- Skip (macro defined): write with byteen=64'h000F -> exactly one bus_wen beat at base address, strobe 4'hF; undefined -> 16 beats, 15 with strobe 4'h0.
